vram_master: RTL and testbench

VRAM_MASTER -- requirements
Module: vram_master

---
 rtl/vram_master.sv | 167 ++++++++++++++++
 tb/tb_vram_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_master.sv
// Word-wide command front end that splits 16-bit accesses onto two 8-bit toggle-handshake VRAM ports.
// Define VRAM_MASTER_FIFO_EN for a 4-entry command FIFO; otherwise a single holding register is used.
module vram_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [14:0] cmd_addr,
    input  logic        cmd_we,
    input  logic [1:0]  cmd_be,
    input  logic [15:0] cmd_wdata,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        idle,
    output logic [14:0] vram1_addr,
    output logic        vram1_req,
    input  logic        vram1_ack,
    output logic        vram1_we,
    output logic [7:0]  vram1_din,
    input  logic [7:0]  vram1_dout,
    output logic [14:0] vram2_addr,
    output logic        vram2_req,
    input  logic        vram2_ack,
    output logic        vram2_we,
    output logic [7:0]  vram2_din,
    input  logic [7:0]  vram2_dout
);

    typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;

    typedef struct packed {
        logic [14:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
    } cmd_t;

    state_t     state;
    cmd_t       head;
    cmd_t       push_cmd;
    logic       push;
    logic       pop;
    logic       queue_empty;
    logic [1:0] lane_mask;
    logic       is_read;
    logic       lanes_done;

    assign push_cmd = '{addr: cmd_addr, we: cmd_we, be: cmd_be, wdata: cmd_wdata};
    assign push     = cmd_valid && cmd_ready;
    assign pop      = (state == IDLE) && !queue_empty;

`ifdef VRAM_MASTER_FIFO_EN
    cmd_t       fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    assign queue_empty = (count == 3'd0);
    assign cmd_ready   = (count != 3'd4) && (state != SYNC);
    assign head        = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    cmd_t hold_q;
    logic hold_full;

    assign queue_empty = !hold_full;
    assign cmd_ready   = !hold_full && (state != SYNC);
    assign head        = hold_q;

    // Push only happens while empty and pop only while full, so they never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (push) begin
            hold_q    <= push_cmd;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end
`endif

    assign idle = (state == IDLE) && queue_empty;

    assign lanes_done = (!lane_mask[0] || (vram1_req == vram1_ack)) &&
                        (!lane_mask[1] || (vram2_req == vram2_ack));

    // Only lanes whose req was toggled gate completion, so single-lane accesses never wait on the idle port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            vram1_addr <= '0;
            vram1_req  <= 1'b0;
            vram1_we   <= 1'b0;
            vram1_din  <= '0;
            vram2_addr <= '0;
            vram2_req  <= 1'b0;
            vram2_we   <= 1'b0;
            vram2_din  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            lane_mask  <= 2'b00;
            is_read    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                SYNC: begin
                    if ((vram1_req == vram1_ack) && (vram2_req == vram2_ack))
                        state <= IDLE;
                end
                IDLE: begin
                    if (!queue_empty) begin
                        vram1_addr <= head.addr;
                        vram2_addr <= head.addr;
                        vram1_we   <= head.we;
                        vram2_we   <= head.we;
                        vram1_din  <= head.wdata[7:0];
                        vram2_din  <= head.wdata[15:8];
                        lane_mask  <= head.be;
                        is_read    <= !head.we;
                        if (head.be[0])
                            vram1_req <= ~vram1_req;
                        if (head.be[1])
                            vram2_req <= ~vram2_req;
                        if (head.be != 2'b00)
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (lanes_done) begin
                        state <= IDLE;
                        if (is_read) begin
                            rd_valid <= 1'b1;
                            rd_data  <= {lane_mask[1] ? vram2_dout : 8'h00,
                                         lane_mask[0] ? vram1_dout : 8'h00};
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_master.sv
// Directed, table-driven bench for vram_master with a byte-wide toggle-handshake responder on each port.
module tb_vram_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_addr;
    logic        cmd_we;
    logic [1:0]  cmd_be;
    logic [15:0] cmd_wdata;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        idle;
    logic [14:0] vram1_addr;
    logic        vram1_req;
    logic        vram1_ack;
    logic        vram1_we;
    logic [7:0]  vram1_din;
    logic [7:0]  vram1_dout;
    logic [14:0] vram2_addr;
    logic        vram2_req;
    logic        vram2_ack;
    logic        vram2_we;
    logic [7:0]  vram2_din;
    logic [7:0]  vram2_dout;

    vram_master dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_we     (cmd_we),
        .cmd_be     (cmd_be),
        .cmd_wdata  (cmd_wdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .idle       (idle),
        .vram1_addr (vram1_addr),
        .vram1_req  (vram1_req),
        .vram1_ack  (vram1_ack),
        .vram1_we   (vram1_we),
        .vram1_din  (vram1_din),
        .vram1_dout (vram1_dout),
        .vram2_addr (vram2_addr),
        .vram2_req  (vram2_req),
        .vram2_ack  (vram2_ack),
        .vram2_we   (vram2_we),
        .vram2_din  (vram2_din),
        .vram2_dout (vram2_dout)
    );

`ifdef VRAM_MASTER_FIFO_EN
    localparam logic READY_AFTER_FIRST = 1'b1;
`else
    localparam logic READY_AFTER_FIRST = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Responder: acks resp_delay cycles after seeing req != ack; hold_ack pins ack high.
    logic       hold_ack = 1'b1;
    int         resp_delay = 0;
    logic [1:0] ack_r = 2'b00;
    logic [7:0] dout_r [2] = '{8'h00, 8'h00};
    int         cnt [2] = '{0, 0};
    int         wr_count [2] = '{0, 0};
    logic [7:0] mem [0:1][0:32767];
    logic [1:0] req_w;
    logic [1:0] we_w;
    logic [14:0] addr_w [2];
    logic [7:0]  din_w [2];

    assign req_w     = {vram2_req, vram1_req};
    assign we_w      = {vram2_we, vram1_we};
    assign addr_w[0] = vram1_addr;
    assign addr_w[1] = vram2_addr;
    assign din_w[0]  = vram1_din;
    assign din_w[1]  = vram2_din;
    assign vram1_ack  = ack_r[0];
    assign vram2_ack  = ack_r[1];
    assign vram1_dout = dout_r[0];
    assign vram2_dout = dout_r[1];

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (hold_ack) begin
                ack_r[p] <= 1'b1;
                cnt[p]   <= 0;
            end else if (req_w[p] != ack_r[p]) begin
                if (cnt[p] >= resp_delay) begin
                    if (we_w[p]) begin
                        mem[p][addr_w[p]] = din_w[p];
                        wr_count[p] = wr_count[p] + 1;
                    end else begin
                        dout_r[p] <= mem[p][addr_w[p]];
                    end
                    ack_r[p] <= req_w[p];
                    cnt[p]   <= 0;
                end else begin
                    cnt[p] <= cnt[p] + 1;
                end
            end else begin
                cnt[p] <= 0;
            end
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor on the falling edge: read pulses, captured words and req toggles.
    int          rv_count = 0;
    logic [15:0] rv_data = 16'h0000;
    int          rv_cycle = 0;
    logic [15:0] rv_q [$];
    int          tog1 = 0;
    int          tog2 = 0;
    logic        prev1 = 1'b0;
    logic        prev2 = 1'b0;

    always @(negedge clk) begin
        if (rd_valid) begin
            rv_count = rv_count + 1;
            rv_data  = rd_data;
            rv_cycle = cycle;
            rv_q.push_back(rd_data);
        end
        if (vram1_req !== prev1) tog1 = tog1 + 1;
        if (vram2_req !== prev2) tog2 = tog2 + 1;
        prev1 = vram1_req;
        prev2 = vram2_req;
    end

    int acc_cycle = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Send one command, then wait for the master to go idle again.
    task automatic applyStimulus(input logic [14:0] a, input logic w, input logic [1:0] b, input logic [15:0] d);
        int n;
        cmd_addr  = a;
        cmd_we    = w;
        cmd_be    = b;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            stepCycle();
            n++;
        end
        checkOutput("accept ready", {31'd0, cmd_ready}, 32'd1);
        stepCycle();
        cmd_valid = 1'b0;
        acc_cycle = cycle;
        n = 0;
        while (!idle && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("complete idle", {31'd0, idle}, 32'd1);
        repeat (2) stepCycle();
    endtask

    typedef struct {
        logic [14:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          exp_pulses;
        logic [15:0] exp_data;
        int          exp_tog1;
        int          exp_tog2;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          p0;
        int          t1;
        int          t2;
        int          n;
        int          n_acc;
        int          base;
        logic        was_ready;
        logic        ready_first;
        logic        ready_fifth;
        logic [15:0] last_rd;
        logic [15:0] exp_word;

        vecs[0] = '{15'h1234, 1'b1, 2'b11, 16'hBEEF, 0, 16'h0000, 1, 1};
        vecs[1] = '{15'h1234, 1'b0, 2'b11, 16'h0000, 1, 16'hBEEF, 1, 1};
        vecs[2] = '{15'h0001, 1'b0, 2'b01, 16'h0000, 1, 16'h005A, 1, 0};
        vecs[3] = '{15'h0001, 1'b0, 2'b10, 16'h0000, 1, 16'hC300, 0, 1};
        vecs[4] = '{15'h0001, 1'b1, 2'b10, 16'h7711, 0, 16'h0000, 0, 1};
        vecs[5] = '{15'h0001, 1'b0, 2'b11, 16'h0000, 1, 16'h775A, 1, 1};
        vecs[6] = '{15'h0002, 1'b1, 2'b00, 16'hFFFF, 0, 16'h0000, 0, 0};
        vecs[7] = '{15'h7FFF, 1'b0, 2'b11, 16'h0000, 1, 16'h3412, 1, 1};
        vecs[8] = '{15'h4000, 1'b1, 2'b01, 16'hAAAA, 0, 16'h0000, 1, 0};
        vecs[9] = '{15'h4000, 1'b0, 2'b11, 16'h0000, 1, 16'h66AA, 1, 1};

        mem[0][15'h0001] = 8'h5A;
        mem[1][15'h0001] = 8'hC3;
        mem[0][15'h7FFF] = 8'h12;
        mem[1][15'h7FFF] = 8'h34;
        mem[1][15'h4000] = 8'h66;
        for (int i = 0; i < 5; i++) begin
            mem[0][15'h0200 + 15'(i)] = 8'(8'h11 * (i + 1));
            mem[1][15'h0200 + 15'(i)] = 8'(8'hA0 + i);
        end

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_we    = 1'b0;
        cmd_be    = 2'b00;
        cmd_wdata = '0;

        // Reset values, with the responder holding a stale ack on both ports.
        repeat (3) stepCycle();
        checkOutput("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rst idle", {31'd0, idle}, 32'd0);
        checkOutput("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("rst rd_data", {16'd0, rd_data}, 32'd0);
        checkOutput("rst reqs", {30'd0, vram2_req, vram1_req}, 32'd0);
        checkOutput("rst wes", {30'd0, vram2_we, vram1_we}, 32'd0);
        checkOutput("rst addr1", {17'd0, vram1_addr}, 32'd0);
        checkOutput("rst addr2", {17'd0, vram2_addr}, 32'd0);
        checkOutput("rst din", {16'd0, vram2_din, vram1_din}, 32'd0);
        reset = 1'b0;

        repeat (5) stepCycle();
        checkOutput("sync held ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("sync held idle", {31'd0, idle}, 32'd0);
        checkOutput("sync held reqs", {30'd0, vram2_req, vram1_req}, 32'd0);

        hold_ack = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("sync exit ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("sync no writes", 32'(wr_count[0] + wr_count[1]), 32'd0);
        checkOutput("sync idle", {31'd0, idle}, 32'd1);

        // Table of single commands with an immediate responder.
        last_rd = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            p0 = rv_count;
            t1 = tog1;
            t2 = tog2;
            applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
            checkOutput($sformatf("v%0d pulses", i), 32'(rv_count - p0), 32'(vecs[i].exp_pulses));
            checkOutput($sformatf("v%0d tog1", i), 32'(tog1 - t1), 32'(vecs[i].exp_tog1));
            checkOutput($sformatf("v%0d tog2", i), 32'(tog2 - t2), 32'(vecs[i].exp_tog2));
            if (vecs[i].exp_pulses != 0) begin
                checkOutput($sformatf("v%0d rd_data", i), {16'd0, rv_data}, {16'd0, vecs[i].exp_data});
                checkOutput($sformatf("v%0d latency", i), 32'(rv_cycle - acc_cycle), 32'd3);
                last_rd = vecs[i].exp_data;
            end else begin
                checkOutput($sformatf("v%0d rd_data hold", i), {16'd0, rd_data}, {16'd0, last_rd});
            end
        end

        // Empty byte enables: the command drains without any port activity.
        p0 = rv_count;
        t1 = tog1;
        t2 = tog2;
        cmd_addr  = 15'h0003;
        cmd_we    = 1'b0;
        cmd_be    = 2'b00;
        cmd_valid = 1'b1;
        checkOutput("be00 ready", {31'd0, cmd_ready}, 32'd1);
        stepCycle();
        cmd_valid = 1'b0;
        checkOutput("be00 idle low", {31'd0, idle}, 32'd0);
        stepCycle();
        checkOutput("be00 idle high", {31'd0, idle}, 32'd1);
        repeat (3) stepCycle();
        checkOutput("be00 toggles", 32'((tog1 - t1) + (tog2 - t2)), 32'd0);
        checkOutput("be00 pulses", 32'(rv_count - p0), 32'd0);

        // Five back-to-back reads against a slow responder.
        resp_delay  = 4;
        base        = rv_q.size();
        n_acc       = 0;
        ready_first = 1'b1;
        ready_fifth = 1'b1;
        cmd_we      = 1'b0;
        cmd_be      = 2'b11;
        cmd_addr    = 15'h0200;
        cmd_valid   = 1'b1;
        for (int c = 0; c < 300 && n_acc < 5; c++) begin
            was_ready = cmd_ready;
            stepCycle();
            if (was_ready) begin
                n_acc++;
                if (n_acc == 1) ready_first = cmd_ready;
                if (n_acc == 5) ready_fifth = cmd_ready;
                cmd_addr = 15'h0200 + 15'(n_acc);
            end
        end
        cmd_valid = 1'b0;
        checkOutput("burst accepts", 32'(n_acc), 32'd5);
        checkOutput("burst ready after 1st", {31'd0, ready_first}, {31'd0, READY_AFTER_FIRST});
        checkOutput("burst ready after 5th", {31'd0, ready_fifth}, 32'd0);
        n = 0;
        while ((rv_q.size() - base) < 5 && n < 300) begin
            stepCycle();
            n++;
        end
        checkOutput("burst completions", 32'(rv_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            exp_word = {8'(8'hA0 + i), 8'(8'h11 * (i + 1))};
            if (base + i < rv_q.size())
                checkOutput($sformatf("burst word %0d", i), {16'd0, rv_q[base + i]}, {16'd0, exp_word});
            else
                checkOutput($sformatf("burst word %0d missing", i), 32'd0, {16'd0, exp_word});
        end
        repeat (3) stepCycle();

        // Reset while a read is outstanding, then recover.
        p0 = rv_count;
        cmd_addr  = 15'h1234;
        cmd_we    = 1'b0;
        cmd_be    = 2'b11;
        cmd_valid = 1'b1;
        checkOutput("midrst ready", {31'd0, cmd_ready}, 32'd1);
        stepCycle();
        cmd_valid = 1'b0;
        repeat (2) stepCycle();
        checkOutput("midrst waiting", {31'd0, idle}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst reqs", {30'd0, vram2_req, vram1_req}, 32'd0);
        checkOutput("midrst ready low", {31'd0, cmd_ready}, 32'd0);
        checkOutput("midrst rd_valid", {31'd0, rd_valid}, 32'd0);
        repeat (2) stepCycle();
        reset = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin
            stepCycle();
            n++;
        end
        checkOutput("midrst resync", {31'd0, cmd_ready}, 32'd1);
        repeat (5) stepCycle();
        checkOutput("midrst no pulse", 32'(rv_count - p0), 32'd0);

        resp_delay = 0;
        applyStimulus(15'h7FFF, 1'b0, 2'b11, 16'h0000);
        checkOutput("post-rst pulses", 32'(rv_count - p0), 32'd1);
        checkOutput("post-rst rd_data", {16'd0, rv_data}, 32'h0000_3412);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
